// File: rtl/demux_1_to_4_router_pkg.sv
// Shared definitions for the 1-to-4 stream router: channel count, select width
// and the routing FSM state type.
package demux_1_to_4_router_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        ROUTE = 1'b1
    } state_e;

    function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        return NUM_CH'(1) << sel;
    endfunction

endpackage

// File: rtl/demux_1_to_4_router_stream_reg_slice.sv
// Single-entry valid/ready register slice. Accepts a new word in the same cycle
// the held word leaves, so a streaming consumer sees no bubbles.
module stream_reg_slice #(
    parameter int W = 9
) (
    input  logic         i_Clk,
    input  logic         i_Rst_L,
    input  logic         i_Valid,
    input  logic [W-1:0] i_Data,
    output logic         o_Ready,
    output logic         o_Valid,
    output logic [W-1:0] o_Data,
    input  logic         i_Ready
);

    logic         full_q, full_d;
    logic [W-1:0] data_q, data_d;

    assign o_Ready = !full_q || i_Ready;
    assign o_Valid = full_q;
    assign o_Data  = data_q;

    // NOTE: every always_comb output gets its hold value first, so no path infers a latch.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (i_Valid && o_Ready) begin
            full_d = 1'b1;
            data_d = i_Data;
        end else if (i_Ready) begin
            full_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/demux_1_to_4_router.sv
// Registered 1-to-4 packet demultiplexer: the channel is picked on a packet's first
// beat and held until its last beat; completed packets are counted per channel.
module demux_1_to_4_router
    import demux_1_to_4_router_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst_L,
    input  logic                        i_Valid,
    input  logic [WIDTH-1:0]            i_Data,
    input  logic                        i_Last,
    input  logic [SEL_W-1:0]            i_Sel,
    output logic                        o_Ready,
    output logic [NUM_CH-1:0]           o_Valid,
    output logic [WIDTH-1:0]            o_Data,
    output logic                        o_Last,
    input  logic [NUM_CH-1:0]           i_Ready,
    output logic                        o_Busy,
    output logic [NUM_CH*CNT_WIDTH-1:0] o_Pkt_Count
);

    state_e                                state_q, state_d;
    logic [SEL_W-1:0]                      sel_q, sel_d;
    logic [NUM_CH-1:0][CNT_WIDTH-1:0]      cnt_q, cnt_d;

    logic in_acc;
    logic out_valid;
    logic out_ready;

    // sel_q always names the channel of the beat held in the slice: it only changes
    // when a first beat is loaded, which is the same edge the old beat leaves.
    assign out_ready = i_Ready[sel_q];
    assign in_acc    = i_Valid && o_Ready;

    stream_reg_slice #(
        .W (WIDTH + 1)
    ) u_out_slice (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Valid (i_Valid),
        .i_Data  ({i_Last, i_Data}),
        .o_Ready (o_Ready),
        .o_Valid (out_valid),
        .o_Data  ({o_Last, o_Data}),
        .i_Ready (out_ready)
    );

    assign o_Valid     = out_valid ? sel_onehot(sel_q) : '0;
    assign o_Busy      = (state_q == ROUTE);
    assign o_Pkt_Count = cnt_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        if (in_acc) begin
            if (state_q == IDLE) begin
                sel_d = i_Sel;
            end
            state_d = i_Last ? IDLE : ROUTE;
        end
        if (out_valid && out_ready && o_Last) begin
            cnt_d[sel_q] = cnt_q[sel_q] + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_demux_1_to_4_router.sv
// Self-checking bench: directed scenarios plus random traffic, compared every cycle
// against a packet-level model holding a queue of pending output beats.
module tb_demux_1_to_4_router;

    logic        clk;
    logic        rst_l;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic [1:0]  in_sel;
    logic        dut_ready;
    logic [3:0]  dut_valid;
    logic [7:0]  dut_data;
    logic        dut_last;
    logic [3:0]  ch_ready;
    logic        dut_busy;
    logic [31:0] dut_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] ch;
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t      pend_q[$];
    logic [7:0] cnt_m[4];
    bit         in_pkt_m;
    logic [1:0] pkt_ch_m;

    demux_1_to_4_router #(.WIDTH(8), .CNT_WIDTH(8)) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_l),
        .i_Valid     (in_valid),
        .i_Data      (in_data),
        .i_Last      (in_last),
        .i_Sel       (in_sel),
        .o_Ready     (dut_ready),
        .o_Valid     (dut_valid),
        .o_Data      (dut_data),
        .o_Last      (dut_last),
        .i_Ready     (ch_ready),
        .o_Busy      (dut_busy),
        .o_Pkt_Count (dut_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_counts();
        return {cnt_m[3], cnt_m[2], cnt_m[1], cnt_m[0]};
    endfunction

    task automatic model_clear();
        pend_q.delete();
        for (int i = 0; i < 4; i++) cnt_m[i] = 8'd0;
        in_pkt_m = 1'b0;
        pkt_ch_m = 2'd0;
    endtask

    // Drive one cycle, compare all outputs before the edge, then advance the model.
    task automatic cycle(input bit v, input logic [7:0] d, input bit l,
                         input logic [1:0] s, input logic [3:0] r);
        bit         have;
        bit         exp_ready;
        bit         out_acc;
        bit         in_acc;
        logic [1:0] dest;
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        in_sel   = s;
        ch_ready = r;
        #1;
        have      = (pend_q.size() != 0);
        exp_ready = !have || r[pend_q[0].ch];
        check("ready", 32'(dut_ready), 32'(exp_ready));
        check("valid", 32'(dut_valid), have ? 32'(4'b0001 << pend_q[0].ch) : 32'd0);
        if (have) begin
            check("data", 32'(dut_data), 32'(pend_q[0].data));
            check("last", 32'(dut_last), 32'(pend_q[0].last));
        end
        check("busy", 32'(dut_busy), 32'(in_pkt_m));
        check("count", dut_count, model_counts());
        @(posedge clk);
        out_acc = have && r[pend_q[0].ch];
        in_acc  = v && exp_ready;
        if (out_acc) begin
            if (pend_q[0].last) cnt_m[pend_q[0].ch] = cnt_m[pend_q[0].ch] + 8'd1;
            void'(pend_q.pop_front());
        end
        if (in_acc) begin
            dest = in_pkt_m ? pkt_ch_m : s;
            pend_q.push_back('{ch: dest, data: d, last: l});
            pkt_ch_m = dest;
            in_pkt_m = !l;
        end
    endtask

    task automatic idle_cycle(input logic [3:0] r);
        cycle(1'b0, 8'h00, 1'b0, 2'd0, r);
    endtask

    // Asynchronous reset pulse between edges; outputs must clear without a clock.
    task automatic pulse_reset();
        @(negedge clk);
        #2;
        rst_l    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_valid", 32'(dut_valid), 32'd0);
        check("rst_data", 32'(dut_data), 32'd0);
        check("rst_last", 32'(dut_last), 32'd0);
        check("rst_busy", 32'(dut_busy), 32'd0);
        check("rst_count", dut_count, 32'd0);
        check("rst_ready", 32'(dut_ready), 32'd1);
        model_clear();
        @(posedge clk);
        #2;
        rst_l = 1'b1;
    endtask

    initial begin
        rst_l    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        in_sel   = 2'd0;
        ch_ready = 4'h0;
        model_clear();
        repeat (2) @(posedge clk);
        pulse_reset();

        // 1: three-beat packet on channel 2.
        cycle(1'b1, 8'hA1, 1'b0, 2'd2, 4'hF);
        cycle(1'b1, 8'hA2, 1'b0, 2'd2, 4'hF);
        cycle(1'b1, 8'hA3, 1'b1, 2'd2, 4'hF);
        idle_cycle(4'hF);
        idle_cycle(4'hF);
        check("t1_count", dut_count, 32'h0001_0000);

        // 2: select changes mid-packet are ignored.
        cycle(1'b1, 8'hB1, 1'b0, 2'd0, 4'hF);
        cycle(1'b1, 8'hB2, 1'b0, 2'd1, 4'hF);
        cycle(1'b1, 8'hB3, 1'b1, 2'd1, 4'hF);
        idle_cycle(4'hF);
        idle_cycle(4'hF);
        check("t2_count", dut_count, 32'h0001_0001);

        // 3: back-to-back single-beat packets on different channels.
        cycle(1'b1, 8'h11, 1'b1, 2'd3, 4'hF);
        cycle(1'b1, 8'h22, 1'b1, 2'd0, 4'hF);
        cycle(1'b1, 8'h33, 1'b1, 2'd1, 4'hF);
        idle_cycle(4'hF);
        idle_cycle(4'hF);
        check("t3_count", dut_count, 32'h0101_0102);

        // 4: channel 1 stalls for five cycles mid-packet.
        cycle(1'b1, 8'hC1, 1'b0, 2'd1, 4'hF);
        cycle(1'b1, 8'hC2, 1'b0, 2'd1, 4'hF);
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'hC3, 1'b0, 2'd1, 4'hD);
        cycle(1'b1, 8'hC3, 1'b0, 2'd1, 4'hF);
        cycle(1'b1, 8'hC4, 1'b1, 2'd1, 4'hF);
        idle_cycle(4'hF);
        idle_cycle(4'hF);
        check("t4_count", dut_count, 32'h0101_0202);

        // 5: reset during beat 2 of 4, then a new packet uses its own select.
        cycle(1'b1, 8'hD1, 1'b0, 2'd1, 4'hF);
        cycle(1'b1, 8'hD2, 1'b0, 2'd1, 4'hF);
        pulse_reset();
        cycle(1'b1, 8'hE1, 1'b0, 2'd2, 4'hF);
        cycle(1'b1, 8'hE2, 1'b1, 2'd0, 4'hF);
        idle_cycle(4'hF);
        idle_cycle(4'hF);
        check("t5_count", dut_count, 32'h0001_0000);

        // 6: 257 packets to channel 3 wrap its counter to 1.
        pulse_reset();
        for (int i = 0; i < 257; i++) cycle(1'b1, 8'(i), 1'b1, 2'd3, 4'hF);
        idle_cycle(4'hF);
        idle_cycle(4'hF);
        check("t6_wrap", dut_count, 32'h0100_0000);

        // Random traffic with random per-channel back-pressure.
        pulse_reset();
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0,
                  2'($urandom), {$urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0});
        end
        for (int i = 0; i < 4; i++) idle_cycle(4'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
